// File: rtl/lsu_ctrl.sv
// Load/store unit control: address generation, fault checks,
// 3-cycle load handshake with the memory arbiter and writeback.
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] base_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_idx_i,
  input  logic        flush_i,
  input  logic [31:0] load_rdata_i,
  output logic [31:0] lsu_addr_ex_o,
  output logic [31:0] lsu_wr_data_o,
  output logic [3:0]  bytemask_unshifted_o,
  output logic        signed_o,
  output logic        lsu_read_o,
  output logic        lsu_write_o,
  output logic        lsu_stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        exc_valid_o,
  output logic [3:0]  exc_cause_o,
  output logic [31:0] exc_addr_o
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LD1,
    S_LD2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] w_addr;
  logic        w_accept;
  logic        w_illegal;
  logic        w_misal;
  logic        w_afault;
  logic        w_fault;
  logic [3:0]  w_cause;
  logic        w_ld_ok;
  logic        w_st_ok;
  logic        w_busy;

  logic        r_signed;
  logic        r_wb_en;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_exc_valid;
  logic [3:0]  r_exc_cause;
  logic [31:0] r_exc_addr;

  assign w_addr    = base_i + imm_i;
  assign w_busy    = (r_state == S_LD1) | (r_state == S_LD2);
  assign w_accept  = rst_n_i & req_valid_i & (r_state == S_IDLE) & ~flush_i;

  assign w_illegal = is_store_i ? (funct3_i >= 3'd3)
                                : ((funct3_i == 3'd3) | (funct3_i[2:1] == 2'b11));
  assign w_misal   = ((funct3_i[1:0] == 2'b01) & w_addr[0])
                   | ((funct3_i[1:0] == 2'b10) & (|w_addr[1:0]));
  assign w_afault  = |w_addr[31:AW];
  assign w_fault   = w_illegal | w_misal | w_afault;

  // Priority order matters: illegal beats misaligned beats range fault.
  always_comb begin
    w_cause = 4'd0;
    if (w_illegal)     w_cause = 4'd2;
    else if (w_misal)  w_cause = is_store_i ? 4'd6 : 4'd4;
    else if (w_afault) w_cause = is_store_i ? 4'd7 : 4'd5;
  end

  assign w_ld_ok = w_accept & ~is_store_i & ~w_fault;
  assign w_st_ok = w_accept & is_store_i & ~w_fault;

  assign lsu_addr_ex_o = w_addr;
  assign lsu_wr_data_o = store_data_i;
  assign lsu_read_o    = w_ld_ok;
  assign lsu_write_o   = w_st_ok;
  assign lsu_stall_o   = rst_n_i & w_busy;
  assign signed_o      = w_ld_ok ? ~funct3_i[2] : r_signed;

  always_comb begin
    bytemask_unshifted_o = 4'b0000;
    case (funct3_i[1:0])
      2'b00:   bytemask_unshifted_o = 4'b0001;
      2'b01:   bytemask_unshifted_o = 4'b0011;
      2'b10:   bytemask_unshifted_o = 4'b1111;
      default: bytemask_unshifted_o = 4'b0000;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ld_ok) w_next = S_LD1;
      S_LD1:   w_next = flush_i ? S_IDLE : S_LD2;
      S_LD2:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_signed    <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= 4'd0;
      r_exc_addr  <= 32'd0;
    end else begin
      r_exc_valid <= w_accept & w_fault;
      if (w_accept & w_fault) begin
        r_exc_cause <= w_cause;
        r_exc_addr  <= w_addr;
      end
      if (w_ld_ok) begin
        r_signed <= ~funct3_i[2];
        r_wb_rd  <= rd_idx_i;
        r_wb_en  <= |rd_idx_i;
      end
      // A flush during the last wait cycle kills the writeback.
      r_wb_valid <= (r_state == S_LD2) & ~flush_i & r_wb_en;
      if ((r_state == S_LD2) && !flush_i)
        r_wb_data <= load_rdata_i;
    end
  end

  assign wb_valid_o  = r_wb_valid;
  assign wb_rd_o     = r_wb_rd;
  assign wb_data_o   = r_wb_data;
  assign exc_valid_o = r_exc_valid;
  assign exc_cause_o = r_exc_cause;
  assign exc_addr_o  = r_exc_addr;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios pinned by literals plus
// random traffic checked against a timestamp-based reference model.
module tb_lsu_ctrl;

  localparam int MEM = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] imm;
  logic [31:0] store_data;
  logic [4:0]  rd_idx;
  logic        flush;
  logic [31:0] load_rdata;
  logic [31:0] addr_o;
  logic [31:0] wr_data_o;
  logic [3:0]  mask_o;
  logic        signed_o;
  logic        read_o;
  logic        write_o;
  logic        stall_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        exc_valid_o;
  logic [3:0]  exc_cause_o;
  logic [31:0] exc_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  lsu_ctrl #(.MEM_BYTES(MEM)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .req_valid_i(req_valid),
    .is_store_i(is_store),
    .funct3_i(funct3),
    .base_i(base),
    .imm_i(imm),
    .store_data_i(store_data),
    .rd_idx_i(rd_idx),
    .flush_i(flush),
    .load_rdata_i(load_rdata),
    .lsu_addr_ex_o(addr_o),
    .lsu_wr_data_o(wr_data_o),
    .bytemask_unshifted_o(mask_o),
    .signed_o(signed_o),
    .lsu_read_o(read_o),
    .lsu_write_o(write_o),
    .lsu_stall_o(stall_o),
    .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o),
    .exc_valid_o(exc_valid_o),
    .exc_cause_o(exc_cause_o),
    .exc_addr_o(exc_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] classify(input logic st,
                                          input logic [2:0] f3,
                                          input logic [31:0] a);
    if (st && f3 >= 3'd3) return 4'd2;
    if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 4'd2;
    if (f3[1:0] == 2'b01 && a[0]) return st ? 4'd6 : 4'd4;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return st ? 4'd6 : 4'd4;
    if (a >= 32'(MEM)) return st ? 4'd7 : 4'd5;
    return 4'd0;
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference model: tracks the cycle a load was accepted and the
  // cycles at which writeback/exception events are due.
  initial begin : model
    int          c;
    int          ld_t;
    int          wb_at;
    int          exc_at;
    logic [4:0]  ld_rd;
    logic        ld_sg;
    logic [31:0] wb_d;
    logic [4:0]  wb_r;
    logic [3:0]  ex_c;
    logic [31:0] ex_a;
    bit          rst_prev;
    bit          busy;
    bit          acc;
    bit          ld_acc;
    logic [31:0] a;
    logic [3:0]  cs;
    c = 0; ld_t = -1; wb_at = -1; exc_at = -1; rst_prev = 0;
    ld_rd = 0; ld_sg = 0; wb_d = 0; wb_r = 0; ex_c = 0; ex_a = 0;
    forever begin
      @(negedge clk);
      c++;
      busy   = (ld_t >= 0) && (c > ld_t) && (c <= ld_t + 2);
      a      = base + imm;
      cs     = classify(is_store, funct3, a);
      acc    = rst_n && req_valid && !busy && !flush;
      ld_acc = acc && !is_store && cs == 0;
      chk("addr", addr_o, a);
      chk("wr_data", wr_data_o, store_data);
      chk("mask", 32'(mask_o), 32'(mask_of(funct3)));
      chk("read", 32'(read_o), 32'(ld_acc));
      chk("write", 32'(write_o), 32'(acc && is_store && cs == 0));
      chk("stall", 32'(stall_o), 32'(rst_n && busy));
      chk("wb_valid", 32'(wb_valid_o), 32'(wb_at == c));
      chk("exc_valid", 32'(exc_valid_o), 32'(exc_at == c));
      if (wb_at == c) begin
        chk("wb_data", wb_data_o, wb_d);
        chk("wb_rd", 32'(wb_rd_o), 32'(wb_r));
      end
      if (exc_at == c) begin
        chk("exc_cause", 32'(exc_cause_o), 32'(ex_c));
        chk("exc_addr", exc_addr_o, ex_a);
      end
      if (ld_acc) chk("signed_acc", 32'(signed_o), 32'(!funct3[2]));
      else if (rst_n && busy) chk("signed_hold", 32'(signed_o), 32'(ld_sg));
      else if (rst_prev) chk("signed_rst", 32'(signed_o), 32'd0);
      if (rst_prev) begin
        chk("wb_data_rst", wb_data_o, 32'd0);
        chk("wb_rd_rst", 32'(wb_rd_o), 32'd0);
        chk("cause_rst", 32'(exc_cause_o), 32'd0);
        chk("eaddr_rst", exc_addr_o, 32'd0);
      end
      if (!rst_n) begin
        ld_t = -1; wb_at = -1; exc_at = -1; rst_prev = 1;
      end else begin
        rst_prev = 0;
        if (busy && flush) ld_t = -1;
        else if (busy && c == ld_t + 2) begin
          if (ld_rd != 0) begin
            wb_at = c + 1; wb_d = load_rdata; wb_r = ld_rd;
          end
          ld_t = -1;
        end
        if (acc) begin
          if (cs != 0) begin
            exc_at = c + 1; ex_c = cs; ex_a = a;
          end else if (!is_store) begin
            ld_t = c; ld_rd = rd_idx; ld_sg = !funct3[2];
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid = 0; is_store = 0; funct3 = 0; base = 0; imm = 0;
    store_data = 0; rd_idx = 0; flush = 0; load_rdata = 0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] sd, input logic [4:0] rd);
    req_valid = 1; is_store = st; funct3 = f3; base = b; imm = im;
    store_data = sd; rd_idx = rd;
  endtask

  initial begin : stim
    idle_in();
    rst_n = 0;
    repeat (3) step();
    @(negedge clk);
    chk("pin_rst_wbv", 32'(wb_valid_o), 32'd0);
    chk("pin_rst_excv", 32'(exc_valid_o), 32'd0);
    chk("pin_rst_wbd", wb_data_o, 32'd0);
    chk("pin_rst_sgn", 32'(signed_o), 32'd0);
    chk("pin_rst_stall", 32'(stall_o), 32'd0);
    step(); rst_n = 1;

    // LW 0x100+4, then back-to-back LB in the writeback cycle
    step(); issue(0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5);
    @(negedge clk);
    chk("pin_lw_read", 32'(read_o), 32'd1);
    chk("pin_lw_addr", addr_o, 32'h104);
    chk("pin_lw_mask", 32'(mask_o), 32'hF);
    step(); idle_in(); load_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("pin_lw_stall1", 32'(stall_o), 32'd1);
    step(); load_rdata = 32'hCAFE_BABE;
    @(negedge clk);
    chk("pin_lw_stall2", 32'(stall_o), 32'd1);
    step(); idle_in(); issue(0, 3'b000, 32'h10, 32'hFFFF_FFFF, 32'h0, 5'd7);
    @(negedge clk);
    chk("pin_lw_wbv", 32'(wb_valid_o), 32'd1);
    chk("pin_lw_wbd", wb_data_o, 32'hCAFE_BABE);
    chk("pin_lw_wbrd", 32'(wb_rd_o), 32'd5);
    chk("pin_lb_addr", addr_o, 32'h0F);
    chk("pin_lb_read", 32'(read_o), 32'd1);
    chk("pin_lb_sgn0", 32'(signed_o), 32'd1);
    step(); idle_in();
    @(negedge clk);
    chk("pin_lb_sgn1", 32'(signed_o), 32'd1);
    step(); load_rdata = 32'hFFFF_FF80;
    @(negedge clk);
    chk("pin_lb_sgn2", 32'(signed_o), 32'd1);
    step(); idle_in();
    @(negedge clk);
    chk("pin_lb_wbv", 32'(wb_valid_o), 32'd1);
    chk("pin_lb_wbd", wb_data_o, 32'hFFFF_FF80);

    // SH misaligned at 0x203
    step(); issue(1, 3'b001, 32'h200, 32'h3, 32'hDEAD_BEEF, 5'd0);
    @(negedge clk);
    chk("pin_sh_write", 32'(write_o), 32'd0);
    step(); idle_in();
    @(negedge clk);
    chk("pin_sh_excv", 32'(exc_valid_o), 32'd1);
    chk("pin_sh_cause", 32'(exc_cause_o), 32'd6);
    chk("pin_sh_eaddr", exc_addr_o, 32'h203);
    step();
    @(negedge clk);
    chk("pin_sh_excv2", 32'(exc_valid_o), 32'd0);

    // LW out of range
    step(); issue(0, 3'b010, 32'h2000, 32'h0, 32'h0, 5'd1);
    @(negedge clk);
    chk("pin_oor_read", 32'(read_o), 32'd0);
    step(); idle_in();
    @(negedge clk);
    chk("pin_oor_cause", 32'(exc_cause_o), 32'd5);
    chk("pin_oor_eaddr", exc_addr_o, 32'h2000);

    // LW flushed in LD1, then SW
    step(); issue(0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    chk("pin_fl_read", 32'(read_o), 32'd1);
    step(); idle_in(); flush = 1;
    @(negedge clk);
    chk("pin_fl_stall", 32'(stall_o), 32'd1);
    step(); flush = 0; issue(1, 3'b010, 32'h80, 32'h4, 32'h1234_5678, 5'd0);
    @(negedge clk);
    chk("pin_fl_stall0", 32'(stall_o), 32'd0);
    chk("pin_sw_write", 32'(write_o), 32'd1);
    chk("pin_sw_addr", addr_o, 32'h84);
    step(); idle_in();
    @(negedge clk);
    chk("pin_fl_nowb", 32'(wb_valid_o), 32'd0);

    // Reset during LD2
    step(); issue(0, 3'b010, 32'h0, 32'h8, 32'h0, 5'd9);
    step(); idle_in();
    step(); rst_n = 0; load_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("pin_r2_stall", 32'(stall_o), 32'd0);
    step(); load_rdata = 0;
    @(negedge clk);
    chk("pin_r2_wbrd", 32'(wb_rd_o), 32'd0);
    chk("pin_r2_wbd", wb_data_o, 32'd0);
    step(); rst_n = 1;
    @(negedge clk);
    chk("pin_r2_nowb", 32'(wb_valid_o), 32'd0);

    repeat (3000) begin
      step();
      rst_n      = ($urandom_range(99) != 0);
      req_valid  = 1'($urandom_range(1));
      is_store   = 1'($urandom_range(1));
      funct3     = 3'($urandom_range(7));
      if ($urandom_range(3) == 0) begin
        base = $urandom; imm = $urandom;
      end else begin
        base = 32'($urandom_range(MEM + 64));
        imm  = 32'($urandom_range(15)) - 32'd8;
      end
      if ($urandom_range(1) == 1) begin
        base[1:0] = 2'b00; imm[1:0] = 2'b00;
      end
      rd_idx     = 5'($urandom_range(31));
      flush      = ($urandom_range(9) == 0);
      store_data = $urandom;
      load_rdata = $urandom;
    end
    step(); idle_in(); rst_n = 1;
    repeat (5) step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
